// File: rtl/led_blink_sequencer.sv
// Shared status-LED sequencer: captures per-channel events and reports each one
// as a blink code of ch+1 pulses, picking channels round-robin, after a lamp test.
module led_blink_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int ON_CYCLES   = 16384,
    parameter int OFF_CYCLES  = 16384,
    parameter int GAP_CYCLES  = 65536,
    parameter int LAMP_CYCLES = 32768
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ev,
    output logic                      led_n,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] cur_ch,
    output logic [NUM_CH-1:0]         pending
);

    localparam int CW      = $clog2(NUM_CH);
    localparam int BW      = $clog2(NUM_CH + 1);
    localparam int MAX_A   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_B   = (GAP_CYCLES > LAMP_CYCLES) ? GAP_CYCLES : LAMP_CYCLES;
    localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD  = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] LAMP_LOAD = TW'(LAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LAMP,
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t            state, state_next;
    logic [TW-1:0]     timer, timer_next;
    logic [BW-1:0]     blinks_left, blinks_next;
    logic [CW-1:0]     last, last_next;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] grant_clear;
    logic              led_next;
    logic              grant_found;
    logic [CW-1:0]     grant_ch;
    logic [CW-1:0]     idx;

    // Round-robin search: first pending channel strictly after the last grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            int sum;
            sum = int'(last) + i;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            idx = CW'(sum);
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_ch    = idx;
            end
        end
    end

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves it unassigned; otherwise synthesis infers a latch to hold it.
    always_comb begin
        state_next  = state;
        timer_next  = (timer == '0) ? timer : timer - TW'(1);
        blinks_next = blinks_left;
        last_next   = last;
        grant_clear = '0;

        case (state)
            S_LAMP: begin
                if (timer == '0) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (grant_found) begin
                    state_next            = S_ON;
                    timer_next            = ON_LOAD;
                    last_next             = grant_ch;
                    grant_clear[grant_ch] = 1'b1;
                    blinks_next           = BW'(grant_ch) + BW'(1);
                end
            end
            S_ON: begin
                if (timer == '0) begin
                    blinks_next = blinks_left - BW'(1);
                    if (blinks_next == '0) begin
                        state_next = S_GAP;
                        timer_next = GAP_LOAD;
                    end else begin
                        state_next = S_OFF;
                        timer_next = OFF_LOAD;
                    end
                end
            end
            S_OFF: begin
                if (timer == '0) begin
                    state_next = S_ON;
                    timer_next = ON_LOAD;
                end
            end
            S_GAP: begin
                if (timer == '0) state_next = S_IDLE;
            end
            default: begin
                state_next = S_LAMP;
                timer_next = LAMP_LOAD;
            end
        endcase

        // A new event on the channel being granted survives the clear.
        pending_next = (pending & ~grant_clear) | ev;
        led_next     = !((state_next == S_LAMP) || (state_next == S_ON));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LAMP;
            timer       <= LAMP_LOAD;
            blinks_left <= '0;
            last        <= CW'(NUM_CH - 1);
            pending     <= '0;
            led_n       <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            blinks_left <= blinks_next;
            last        <= last_next;
            pending     <= pending_next;
            led_n       <= led_next;
        end
    end

    assign busy   = (state != S_IDLE);
    assign cur_ch = last;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer: lamp test, table-driven blink codes,
// round-robin order, event collapsing, set-wins capture and mid-code reset.
module tb_led_blink_sequencer;

    localparam int NUM_CH = 4;
    localparam int ON_C   = 4;
    localparam int OFF_C  = 3;
    localparam int GAP_C  = 10;
    localparam int LAMP_C = 8;

    logic       clk;
    logic       rst;
    logic [3:0] ev;
    logic       led_n;
    logic       busy;
    logic [1:0] cur_ch;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    led_blink_sequencer #(
        .NUM_CH     (NUM_CH),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .GAP_CYCLES (GAP_C),
        .LAMP_CYCLES(LAMP_C)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ev     (ev),
        .led_n  (led_n),
        .busy   (busy),
        .cur_ch (cur_ch),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]      ev;
        logic [1:0]      n;
        logic [2:0][1:0] ch;
        logic [2:0][7:0] len;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Follows one code from its grant sample until busy drops, measuring it.
    task automatic obs(output int ch, output int len, output int blinks, output int bad);
        logic prev;
        int   on_run;
        int   off_run;
        ch = int'(cur_ch);
        len = 0; blinks = 0; bad = 0; prev = 1'b1; on_run = 0; off_run = 0;
        while (busy === 1'b1 && len < 200) begin
            if (cur_ch !== 2'(ch)) bad++;
            if (led_n === 1'b0) begin
                if (prev) begin
                    blinks++;
                    if (blinks > 1 && off_run != OFF_C) bad++;
                    off_run = 0;
                end
                on_run++;
            end else begin
                if (!prev) begin
                    if (on_run != ON_C) bad++;
                    on_run = 0;
                end
                off_run++;
            end
            prev = led_n;
            len++;
            tick();
        end
        if (!prev || off_run != GAP_C) bad++;
    endtask

    task automatic expect_obs(input string tag, input int exp_ch, input int exp_len);
        int g_ch, g_len, g_bl, g_bad;
        obs(g_ch, g_len, g_bl, g_bad);
        check({tag, " ch"}, g_ch, exp_ch);
        check({tag, " busy_len"}, g_len, exp_len);
        check({tag, " blinks"}, g_bl, exp_ch + 1);
        check({tag, " pattern_errs"}, g_bad, 0);
    endtask

    // Steps through the IDLE grant edge, then observes the code.
    task automatic next_code(input string tag, input int exp_ch, input int exp_len);
        tick();
        check({tag, " lit_at_grant"}, led_n, 0);
        expect_obs(tag, exp_ch, exp_len);
    endtask

    // Called right after rst is released; optionally pulses ev during the lamp.
    task automatic lamp(input string tag, input int pulse_at, input logic [3:0] pulse_ev);
        logic [3:0] exp_p;
        logic [3:0] applied;
        exp_p = '0;
        applied = '0;
        for (int i = 1; i <= LAMP_C; i++) begin
            tick();
            exp_p |= applied;
            ev = '0;
            check($sformatf("%s led_n[%0d]", tag, i), led_n, (i == LAMP_C) ? 1 : 0);
            check($sformatf("%s busy[%0d]", tag, i), busy, (i == LAMP_C) ? 0 : 1);
            check($sformatf("%s cur_ch[%0d]", tag, i), cur_ch, 3);
            check($sformatf("%s pending[%0d]", tag, i), pending, exp_p);
            if (i == pulse_at) ev = pulse_ev;
            applied = ev;
        end
        ev = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("reset led_n", led_n, 0);
        check("reset busy", busy, 1);
        check("reset cur_ch", cur_ch, 3);
        check("reset pending", pending, 0);
        rst = 1'b0;
    endtask

    initial begin
        // Expected orders assume the round-robin pointer left by the previous row.
        vecs[0] = '{ev: 4'b1011, n: 2'd3, ch: {2'd3, 2'd1, 2'd0}, len: {8'd35, 8'd21, 8'd14}};
        vecs[1] = '{ev: 4'b0100, n: 2'd1, ch: {2'd0, 2'd0, 2'd2}, len: {8'd0, 8'd0, 8'd28}};
        vecs[2] = '{ev: 4'b0010, n: 2'd1, ch: {2'd0, 2'd0, 2'd1}, len: {8'd0, 8'd0, 8'd21}};
        vecs[3] = '{ev: 4'b1001, n: 2'd2, ch: {2'd0, 2'd0, 2'd3}, len: {8'd0, 8'd14, 8'd35}};

        rst = 1'b1;
        ev  = '0;

        // Lamp test after reset with no events.
        do_reset();
        lamp("lamp1", 0, 4'b0000);

        // Table-driven codes.
        for (int v = 0; v < 4; v++) begin
            ev = vecs[v].ev;
            tick();
            ev = '0;
            check($sformatf("vec%0d captured", v), pending, vecs[v].ev);
            check($sformatf("vec%0d dark_before_grant", v), led_n, 1);
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                next_code($sformatf("vec%0d code%0d", v, j), int'(vecs[v].ch[j]), int'(vecs[v].len[j]));
            end
            check($sformatf("vec%0d pending_after", v), pending, 0);
            check($sformatf("vec%0d idle_after", v), busy, 0);
        end

        // Round-robin: ch0 and ch2 arrive during ch1's code; ch2 goes first.
        ev = 4'b0010;
        tick();
        ev = '0;
        tick();
        check("rr grant ch1 lit", led_n, 0);
        fork
            expect_obs("rr ch1", 1, 21);
            begin
                ev = 4'b0101;
                tick();
                ev = '0;
            end
        join
        next_code("rr ch2", 2, 28);
        next_code("rr ch0", 0, 14);
        check("rr pending_after", pending, 0);

        // Set wins over grant-clear on the same edge.
        ev = 4'b0001;
        tick();
        check("setwin captured", pending, 4'b0001);
        tick();
        ev = '0;
        check("setwin lit", led_n, 0);
        check("setwin cur_ch", cur_ch, 0);
        check("setwin pending_kept", pending, 4'b0001);
        expect_obs("setwin first", 0, 14);
        next_code("setwin second", 0, 14);
        check("setwin pending_after", pending, 0);

        // Event during lamp, repeat event during own ON, five ch3 pulses collapse.
        do_reset();
        lamp("lamp2", 3, 4'b0010);
        tick();
        check("lampev lit", led_n, 0);
        check("lampev cur_ch", cur_ch, 1);
        check("lampev pending_cleared", pending, 0);
        fork
            expect_obs("collapse ch1", 1, 21);
            begin
                ev = 4'b1010;
                tick();
                ev = '0;
                repeat (4) begin
                    tick();
                    ev = 4'b1000;
                    tick();
                    ev = '0;
                end
            end
        join
        check("collapse pending", pending, 4'b1010);
        next_code("collapse ch3", 3, 35);
        next_code("collapse ch1 again", 1, 21);
        repeat (3) begin
            tick();
            check("collapse stays idle", busy, 0);
        end

        // Asynchronous reset during the second blink of ch2.
        ev = 4'b0100;
        tick();
        ev = '0;
        tick();
        ev = 4'b0001;
        tick();
        ev = '0;
        repeat (6) tick();
        check("midrst in blink2 lit", led_n, 0);
        check("midrst pending_before", pending, 4'b0001);
        check("midrst cur_ch_before", cur_ch, 2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst async led_n", led_n, 0);
        check("midrst async pending", pending, 0);
        check("midrst async cur_ch", cur_ch, 3);
        check("midrst async busy", busy, 1);
        tick();
        rst = 1'b0;
        lamp("lamp3", 0, 4'b0000);
        repeat (5) begin
            tick();
            check("midrst no_resume busy", busy, 0);
            check("midrst no_resume led_n", led_n, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Front-panel status LED sequencer for the interface-board FPGA. It captures single-cycle activity or fault events from up to `NUM_CH` sources and shares one open-drain status LED between them. Each captured event is reported as a blink code of `ch+1` pulses. A round-robin arbiter picks the next source, and a lamp test runs after reset. It sits between the event-generating logic and the LED pin, and replaces per-source pulse stretchers wherever only one LED is available.

## Interface
Parameters:
- `NUM_CH`, 4: number of event sources (2..8).
- `ON_CYCLES`, 16384: LED-on time per blink, in clk cycles (≥1).
- `OFF_CYCLES`, 16384: LED-off time between blinks of one code (≥1).
- `GAP_CYCLES`, 65536: LED-off time after the last blink of a code (≥1).
- `LAMP_CYCLES`, 32768: LED-on time of the post-reset lamp test (≥1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ev` in NUM_CH: event pulses, synchronous to clk, active-high, any width.
- `led_n` out 1: LED drive, active-low (0 = lit), registered; drives the open-drain pin directly.
- `busy` out 1: high whenever state ≠ IDLE.
- `cur_ch` out $clog2(NUM_CH): channel being reported; holds the last granted value while IDLE.
- `pending` out NUM_CH: captured, not-yet-granted events.

## Operation
- States: LAMP, IDLE, ON, OFF, GAP.
- One down-counter `timer`, sized to the largest parameter. Entering a timed state loads `duration-1`. A state exits on the cycle its timer reads 0, so each state lasts exactly its duration.
- A blink counter `blinks_left` holds the number of remaining blinks.
- Reset values (asynchronous): state=LAMP, `timer`=LAMP_CYCLES-1, `led_n`=0, `busy`=1, `pending`=0, `cur_ch`=NUM_CH-1, round-robin pointer `last`=NUM_CH-1.
- **LAMP:** LED lit. On timeout, go to IDLE with LED dark.
- **IDLE:** LED dark. If `pending` ≠ 0, grant the first set bit searching upward from `last+1` with wrap-around. On the grant:
  - set `cur_ch` and `last` to the granted channel;
  - clear that `pending` bit;
  - set `blinks_left` = ch+1;
  - go to ON.
- **ON:** LED lit. On timeout:
  - decrement `blinks_left`;
  - if the result is 0, go to GAP; otherwise go to OFF.
- **OFF:** LED dark. On timeout, go to ON.
- **GAP:** LED dark. On timeout, go to IDLE. The next grant can happen in that same IDLE cycle's successor edge.
- Event capture: `pending[i]` is set on any cycle where `ev[i]`=1, in every state including LAMP.
  - If a set and a grant-clear hit the same bit in the same cycle, set wins; the channel is served again later.
  - Multiple pulses on a channel while it is pending collapse into one report.
- Arithmetic: `blinks_left` width is $clog2(NUM_CH+1). The timer never wraps; it is only reloaded on state entry.

## Timing
- `ev[i]` high at edge k sets `pending[i]` after edge k.
- If the block is IDLE at edge k+1, it grants, and `led_n`=0 and `cur_ch` are valid after edge k+1. Latency from event to LED lit is 2 cycles.
- Code duration for channel c: (c+1)·ON_CYCLES + c·OFF_CYCLES + GAP_CYCLES cycles of `busy`=1.
- LED sequence after reset release: `led_n`=0 for LAMP_CYCLES edges, then 1.
- `busy` falls on the same edge that enters IDLE.
- An `rst` assertion mid-code immediately forces LAMP, with the LED lit and pending events discarded. No partial code resumes.

## Test plan
Use NUM_CH=4, ON=4, OFF=3, GAP=10, LAMP=8.
1. Release reset with no events: `led_n`=0 for 8 cycles, then 1. `busy` falls on the same edge. `pending`=0 and `cur_ch`=3 throughout.
2. Single-cycle `ev`=4'b0100 while IDLE: `led_n` goes low 2 cycles later. The LED pattern is three low intervals of 4 cycles separated by 3-cycle highs, then a 10-cycle high. `busy` stays high for 28 cycles and `cur_ch`=2.
3. `ev`=4'b1011 in one cycle while IDLE: codes are reported in order ch0 (1 blink), ch1 (2 blinks), ch3 (4 blinks), with no idle cycle between them beyond the IDLE grant cycle. `pending` then reads 0.
4. Round-robin: after ch1 is granted, pulse ch0 and ch2 during its code. Required order is ch2 then ch0.
5. Pulse `ev[1]` during LAMP, and again during ch1's own ON phase. ch1 is reported after the lamp test, then reported a second time. Five pulses on ch3 during one code produce exactly one ch3 report.
6. Assert `rst` during the second blink of ch2: `led_n`=0 immediately (asynchronously), `pending`=0, and the lamp test restarts with a full 8 cycles after release.
